// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration path:
// sequencer state encoding, frame geometry and the special LUT commands.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    CHECK,
    START,
    BITS,
    STOP,
    GAP,
    ADV,
    DONE
  } cfg_state_t;

  localparam int          SCCB_SLOTS = 27;
  localparam logic [15:0] CMD_RESET  = 16'h1280;
  localparam logic [15:0] CMD_END    = 16'hFFFF;
  localparam int          MAX_RETRY  = 3;

  // Quarter-bit period in system clocks, floored and never below 1.
  function automatic int calc_quarter(input int clk_hz, input int sccb_hz);
    int q;
    q = clk_hz / (4 * sccb_hz);
    return (q < 1) ? 1 : q;
  endfunction

  // The 9th bit of every byte is the slave's acknowledge slot.
  function automatic logic is_ack_slot(input logic [4:0] s);
    return (s == 5'd8) || (s == 5'd17) || (s == 5'd26);
  endfunction

endpackage

// File: rtl/sccb_config_sender_tick.sv
// Quarter-bit strobe generator: one-clock tick every Q clocks, restarted by clear
// so the first quarter after a clear is a full Q clocks long.
module sccb_tick_gen #(
  parameter int Q = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] LAST = CW'(Q - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/sccb_config_sender.sv
// Sends each LUT command as a 3-phase SCCB write (ID, sub-address, data) and steps the LUT.
// Optional macro SCCB_ACK_CHECK_EN enables ACK sampling with retries and the nack_err flag.
module sccb_config_sender
  import ov7670_cfg_pkg::*;
#(
  parameter int         CLK_FREQ_HZ       = 25_000_000,
  parameter int         SCCB_FREQ_HZ      = 100_000,
  parameter logic [7:0] DEV_ID            = 8'h42,
  parameter int         GAP_CYCLES        = 256,
  parameter int         RESET_WAIT_CYCLES = 25_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resend,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        advance,
  output logic        config_done,
  output logic        busy,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        nack_err
);

  localparam int          Q            = calc_quarter(CLK_FREQ_HZ, SCCB_FREQ_HZ);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] GAP_RST_LAST = 32'(GAP_CYCLES + RESET_WAIT_CYCLES - 1);

  cfg_state_t  state;
  logic        settle_cnt;
  logic [23:0] sreg;
  logic        is_reset;
  logic [4:0]  slot;
  logic [4:0]  slot_nxt;
  logic [1:0]  qtr;
  logic [31:0] gap_cnt;
  logic        gap_end;
  logic        resend_pend;
  logic        tick;
  logic        tick_clear;

`ifdef SCCB_ACK_CHECK_EN
  logic [1:0]  retry_cnt;
  logic        nack_frame;
  logic        nack_err_q;
  assign nack_err = nack_err_q;
`else
  logic        unused_siod_in;
  assign unused_siod_in = siod_in;
  assign nack_err       = 1'b0;
`endif

  assign tick_clear = !(state inside {START, BITS, STOP});
  assign slot_nxt   = slot + 5'd1;
  assign gap_end    = (gap_cnt == (is_reset ? GAP_RST_LAST : GAP_LAST));

  sccb_tick_gen #(
    .Q(Q)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(tick_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SETTLE;
      settle_cnt  <= 1'b0;
      sreg        <= '0;
      is_reset    <= 1'b0;
      slot        <= '0;
      qtr         <= '0;
      gap_cnt     <= '0;
      resend_pend <= 1'b0;
      advance     <= 1'b0;
      config_done <= 1'b0;
      busy        <= 1'b0;
      sioc        <= 1'b1;
      siod_out    <= 1'b1;
      siod_oe     <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
      retry_cnt   <= '0;
      nack_frame  <= 1'b0;
      nack_err_q  <= 1'b0;
`endif
    end else begin
      advance <= 1'b0;
      // Outside a frame the bus is already idle, so resend simply restarts the sequence.
      if (resend && !(state inside {START, BITS, STOP})) begin
        state       <= SETTLE;
        settle_cnt  <= 1'b0;
        config_done <= 1'b0;
        busy        <= 1'b0;
        resend_pend <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
        retry_cnt   <= '0;
        nack_err_q  <= 1'b0;
`endif
      end else begin
        if (resend) resend_pend <= 1'b1;
        case (state)
          SETTLE: begin
            if (settle_cnt) begin
              state      <= CHECK;
              settle_cnt <= 1'b0;
            end else begin
              settle_cnt <= 1'b1;
            end
          end
          CHECK: begin
            if (finished || (command == CMD_END)) begin
              state       <= DONE;
              config_done <= 1'b1;
            end else begin
              sreg     <= {DEV_ID, command};
              is_reset <= (command == CMD_RESET);
              state    <= START;
              busy     <= 1'b1;
              qtr      <= '0;
              slot     <= '0;
              sioc     <= 1'b1;
              siod_oe  <= 1'b1;
              siod_out <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
              nack_frame <= 1'b0;
`endif
            end
          end
          START: begin
            if (tick) begin
              if (qtr == 2'd0) begin
                sioc <= 1'b0;
                qtr  <= 2'd1;
              end else begin
                state    <= BITS;
                qtr      <= '0;
                slot     <= '0;
                siod_oe  <= 1'b1;
                siod_out <= sreg[23];
                sreg     <= {sreg[22:0], 1'b0};
              end
            end
          end
          BITS: begin
            if (tick) begin
              case (qtr)
                2'd0: qtr <= 2'd1;
                2'd1: begin
                  qtr  <= 2'd2;
                  sioc <= 1'b1;
                end
                2'd2: begin
                  qtr <= 2'd3;
`ifdef SCCB_ACK_CHECK_EN
                  if (is_ack_slot(slot) && siod_in) nack_frame <= 1'b1;
`endif
                end
                default: begin
                  sioc <= 1'b0;
                  qtr  <= 2'd0;
                  if (slot == 5'(SCCB_SLOTS - 1)) begin
                    state    <= STOP;
                    siod_oe  <= 1'b1;
                    siod_out <= 1'b0;
                  end else begin
                    slot <= slot_nxt;
                    if (is_ack_slot(slot_nxt)) begin
                      siod_oe  <= 1'b0;
                      siod_out <= 1'b1;
                    end else begin
                      siod_oe  <= 1'b1;
                      siod_out <= sreg[23];
                      sreg     <= {sreg[22:0], 1'b0};
                    end
                  end
                end
              endcase
            end
          end
          STOP: begin
            if (tick) begin
              case (qtr)
                2'd0: begin
                  sioc <= 1'b1;
                  qtr  <= 2'd1;
                end
                2'd1: begin
                  siod_out <= 1'b1;
                  qtr      <= 2'd2;
                end
                default: begin
                  siod_oe <= 1'b0;
                  qtr     <= 2'd0;
                  // A resend seen during the frame skips the gap and the LUT step.
                  if (resend_pend || resend) begin
                    state       <= SETTLE;
                    settle_cnt  <= 1'b0;
                    busy        <= 1'b0;
                    resend_pend <= 1'b0;
                    config_done <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
                    retry_cnt   <= '0;
                    nack_err_q  <= 1'b0;
`endif
                  end else begin
                    state   <= GAP;
                    gap_cnt <= '0;
                  end
                end
              endcase
            end
          end
          GAP: begin
            if (gap_end) begin
              busy <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
              if (nack_frame && (retry_cnt < 2'(MAX_RETRY))) begin
                retry_cnt  <= retry_cnt + 2'd1;
                state      <= SETTLE;
                settle_cnt <= 1'b0;
              end else begin
                if (nack_frame) nack_err_q <= 1'b1;
                retry_cnt <= '0;
                state     <= ADV;
                advance   <= 1'b1;
              end
`else
              state   <= ADV;
              advance <= 1'b1;
`endif
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end
          ADV: begin
            state      <= SETTLE;
            settle_cnt <= 1'b0;
          end
          DONE: begin
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
          end
          default: begin
            state      <= SETTLE;
            settle_cnt <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_config_sender.sv
// Directed bench for sccb_config_sender: a small LUT model feeds commands and a bus
// monitor decodes SIOC/SIOD frames, recording timing of START, STOP and advance.
module tb_sccb_config_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resend = 1'b0;
  logic [15:0] command;
  logic        finished;
  logic        advance;
  logic        config_done;
  logic        busy;
  logic        sioc;
  logic        siod_out;
  logic        siod_oe;
  logic        siod_in;
  logic        nack_err;
  logic        stuck_nack = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] tbl [0:63];
  int          n_entries = 0;
  int          lut_addr;

  sccb_config_sender #(
    .CLK_FREQ_HZ      (4_000_000),
    .SCCB_FREQ_HZ     (100_000),
    .DEV_ID           (8'h42),
    .GAP_CYCLES       (16),
    .RESET_WAIT_CYCLES(500)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .resend     (resend),
    .command    (command),
    .finished   (finished),
    .advance    (advance),
    .config_done(config_done),
    .busy       (busy),
    .sioc       (sioc),
    .siod_out   (siod_out),
    .siod_oe    (siod_oe),
    .siod_in    (siod_in),
    .nack_err   (nack_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign siod_in = stuck_nack ? 1'b1 : (siod_oe ? siod_out : 1'b0);

  // LUT model: registered address plus registered data, two clocks from advance to command.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_addr <= 0;
      command  <= 16'h0000;
      finished <= 1'b0;
    end else begin
      if (resend) lut_addr <= 0;
      else if (advance) lut_addr <= lut_addr + 1;
      if (lut_addr >= n_entries) begin
        command  <= 16'hFFFF;
        finished <= 1'b1;
      end else begin
        command  <= tbl[lut_addr];
        finished <= 1'b0;
      end
    end
  end

  // Bus monitor
  int          start_cnt, stop_cnt, adv_cnt, bitn;
  int          start_cyc, stop_cyc, adv_cyc;
  logic [26:0] sh, oe_sh, last_frame, last_oe;
  logic        p_oe, p_sioc;

  always @(negedge clk) begin
    if (rst) begin
      start_cnt = 0; stop_cnt = 0; adv_cnt = 0; bitn = 27;
      start_cyc = 0; stop_cyc = 0; adv_cyc = 0;
      sh = '0; oe_sh = '0; last_frame = '0; last_oe = '0;
      p_oe = 1'b0; p_sioc = 1'b1;
    end else begin
      if (siod_oe && !p_oe && sioc && !siod_out) begin
        start_cnt++; start_cyc = cyc; bitn = 0;
      end
      if (sioc && !p_sioc && bitn < 27) begin
        sh    = {sh[25:0], (siod_oe ? siod_out : 1'b1)};
        oe_sh = {oe_sh[25:0], siod_oe};
        bitn++;
      end
      if (!siod_oe && p_oe && sioc) begin
        stop_cnt++; stop_cyc = cyc; last_frame = sh; last_oe = oe_sh;
      end
      if (advance) begin
        adv_cnt++; adv_cyc = cyc;
      end
      p_oe = siod_oe; p_sioc = sioc;
    end
  end

  function automatic logic [23:0] frame_bytes(input logic [26:0] f);
    return {f[26:19], f[17:10], f[8:1]};
  endfunction

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; resend = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (start_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_stops(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (stop_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_advs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (adv_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (config_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #2 rst = 1'b1; #1;
    tests++; if (sioc !== 1'b1) begin fails++; $display("FAIL rst_sioc got %b want 1", sioc); end
    tests++; if (siod_out !== 1'b1) begin fails++; $display("FAIL rst_siod_out got %b want 1", siod_out); end
    tests++; if (siod_oe !== 1'b0) begin fails++; $display("FAIL rst_siod_oe got %b want 0", siod_oe); end
    tests++; if (advance !== 1'b0) begin fails++; $display("FAIL rst_advance got %b want 0", advance); end
    tests++; if (config_done !== 1'b0) begin fails++; $display("FAIL rst_config_done got %b want 0", config_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (nack_err !== 1'b0) begin fails++; $display("FAIL rst_nack_err got %b want 0", nack_err); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_single_write();
    bit ok;
    tbl[0] = 16'h3E19; n_entries = 1;
    do_reset();
    wait_starts(1, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_start_timeout no START within 50 cycles"); end
    repeat (5) @(posedge clk); #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy); end
    wait_stops(1, 1300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_stop_timeout no STOP within 1300 cycles"); end
    tests++; if (frame_bytes(last_frame) !== 24'h423E19) begin
      fails++; $display("FAIL single_bytes got %h want 423e19", frame_bytes(last_frame)); end
    tests++; if (last_oe !== 27'b111111110111111110111111110) begin
      fails++; $display("FAIL single_oe_mask got %b want 111111110111111110111111110", last_oe); end
    tests++; if (stop_cyc - start_cyc !== 1130) begin
      fails++; $display("FAIL single_frame_len got %0d want 1130", stop_cyc - start_cyc); end
    wait_done(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_done_timeout config_done not seen"); end
    tests++; if (adv_cnt !== 1) begin fails++; $display("FAIL single_adv_count got %0d want 1", adv_cnt); end
    tests++; if (adv_cyc - stop_cyc !== 16) begin
      fails++; $display("FAIL single_gap got %0d want 16", adv_cyc - stop_cyc); end
    tests++; if ({sioc, siod_oe, busy} !== 3'b100) begin
      fails++; $display("FAIL single_idle sioc/oe/busy got %b want 100", {sioc, siod_oe, busy}); end
  endtask

  task automatic test_reset_cmd();
    bit ok;
    tbl[0] = 16'h1280; tbl[1] = 16'h3E19; n_entries = 2;
    do_reset();
    wait_stops(1, 1300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rcmd_stop_timeout no STOP"); end
    tests++; if (frame_bytes(last_frame) !== 24'h421280) begin
      fails++; $display("FAIL rcmd_bytes got %h want 421280", frame_bytes(last_frame)); end
    wait_advs(1, 700, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rcmd_adv_timeout no advance"); end
    tests++; if (adv_cyc - stop_cyc !== 516) begin
      fails++; $display("FAIL rcmd_gap got %0d want 516", adv_cyc - stop_cyc); end
    wait_starts(2, 50, ok);
    tests++; if (!ok || (start_cyc - adv_cyc < 2) || (start_cyc - adv_cyc > 6)) begin
      fails++; $display("FAIL rcmd_next_start got %0d want 2..6", start_cyc - adv_cyc); end
  endtask

  task automatic test_resend_mid_frame();
    bit ok;
    int a0;
    tbl[0] = 16'h1280;
    for (int i = 1; i < 7; i++) tbl[i] = {8'(8'h30 + i), 8'(8'h05 * i)};
    n_entries = 7;
    do_reset();
    wait_starts(6, 12000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL resend_start_timeout entry 5 frame not started"); end
    repeat (300) @(posedge clk);
    #2 resend = 1'b1;
    @(posedge clk); #2 resend = 1'b0;
    a0 = adv_cnt;
    wait_stops(6, 1200, ok);
    tests++; if (!ok || frame_bytes(last_frame) !== {8'h42, tbl[5]}) begin
      fails++; $display("FAIL resend_cur_frame got %h want %h", frame_bytes(last_frame), {8'h42, tbl[5]}); end
    wait_stops(7, 1300, ok);
    tests++; if (!ok || frame_bytes(last_frame) !== 24'h421280) begin
      fails++; $display("FAIL resend_next_frame got %h want 421280", frame_bytes(last_frame)); end
    tests++; if (adv_cnt !== a0) begin fails++; $display("FAIL resend_no_adv got %0d want %0d", adv_cnt, a0); end
    tests++; if (config_done !== 1'b0) begin fails++; $display("FAIL resend_done got %b want 0", config_done); end
  endtask

  task automatic test_full_lut();
    bit ok;
    for (int i = 0; i < 62; i++) tbl[i] = {8'(8'h20 + i), 8'(8'h05 * i)};
    n_entries = 62;
    do_reset();
    wait_done(75000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL lut_done_timeout config_done not seen"); end
    tests++; if (adv_cnt !== 62) begin fails++; $display("FAIL lut_adv_count got %0d want 62", adv_cnt); end
    tests++; if (stop_cnt !== 62) begin fails++; $display("FAIL lut_frames got %0d want 62", stop_cnt); end
    tests++; if (frame_bytes(last_frame) !== {8'h42, tbl[61]}) begin
      fails++; $display("FAIL lut_last_frame got %h want %h", frame_bytes(last_frame), {8'h42, tbl[61]}); end
    tests++; if ({sioc, siod_oe} !== 2'b10) begin
      fails++; $display("FAIL lut_bus_idle sioc/oe got %b want 10", {sioc, siod_oe}); end
    @(posedge clk); #2 resend = 1'b1;
    @(posedge clk); #2 resend = 1'b0;
    @(posedge clk); #1;
    tests++; if (config_done !== 1'b0) begin fails++; $display("FAIL lut_resend_clear got %b want 0", config_done); end
    wait_starts(63, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL lut_restart no START after resend"); end
    tests++; if (adv_cnt !== 62) begin fails++; $display("FAIL lut_resend_no_adv got %0d want 62", adv_cnt); end
  endtask

  task automatic test_async_rst();
    bit ok;
    int n;
    tbl[0] = 16'h3E19; n_entries = 1;
    do_reset();
    wait_starts(1, 50, ok);
    repeat (400) @(posedge clk);
    #2 rst = 1'b1; #1;
    tests++; if ({sioc, siod_oe, advance} !== 3'b100) begin
      fails++; $display("FAIL arst_outputs sioc/oe/adv got %b want 100", {sioc, siod_oe, advance}); end
    @(posedge clk); #2 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; n++;
      if (siod_oe === 1'b1) break;
    end
    tests++; if (siod_oe !== 1'b1 || n < 2 || n > 3) begin
      fails++; $display("FAIL arst_restart clocks to START got %0d want 2..3", n); end
  endtask

`ifdef SCCB_ACK_CHECK_EN
  task automatic test_ack_retry();
    bit ok;
    tbl[0] = 16'h3E19; n_entries = 1;
    stuck_nack = 1'b1;
    do_reset();
    wait_done(8000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ack_done_timeout config_done not seen"); end
    tests++; if (start_cnt !== 4) begin fails++; $display("FAIL ack_frames got %0d want 4", start_cnt); end
    tests++; if (frame_bytes(last_frame) !== 24'h423E19) begin
      fails++; $display("FAIL ack_bytes got %h want 423e19", frame_bytes(last_frame)); end
    tests++; if (adv_cnt !== 1) begin fails++; $display("FAIL ack_adv got %0d want 1", adv_cnt); end
    tests++; if (nack_err !== 1'b1) begin fails++; $display("FAIL ack_nack_err got %b want 1", nack_err); end
    stuck_nack = 1'b0;
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_reset_cmd();
    test_resend_mid_frame();
    test_async_rst();
`ifdef SCCB_ACK_CHECK_EN
    test_ack_retry();
`endif
    test_full_lut();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
